cache_ctrl: RTL and testbench



---
 rtl/cache_pkg.sv | 32 +++
 rtl/cache_ctrl.sv | 156 +++++++++++++++
 tb/tb_cache_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared widths, FSM state type and address-field helpers for the
// direct-mapped write-through cache controller.
package cache_pkg;

   localparam int DATA_W  = 32;
   localparam int INDEX_W = 5;
   localparam int TAG_W   = 6;
   localparam int WORD_W  = 3;
   localparam int ADDR_W  = TAG_W + INDEX_W + WORD_W + 2;
   localparam int CNT_W   = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COMPARE   = 2'd1,
      REFILL    = 2'd2,
      WRITE_MEM = 2'd3
   } state_t;

   // Byte address layout: {tag, index, word, byte[1:0]}
   function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
      return addr[WORD_W+2 +: INDEX_W];
   endfunction

   function automatic logic [WORD_W-1:0] get_word(input logic [ADDR_W-1:0] addr);
      return addr[2 +: WORD_W];
   endfunction

endpackage

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller driving an
// external storage array (async tag/valid/data read) and a word memory port.
module cache_ctrl
   import cache_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [INDEX_W-1:0] st_index,
   output logic [WORD_W-1:0] st_word,
   output logic              st_we_data,
   output logic              st_we_tag,
   output logic [TAG_W-1:0]  st_tag,
   output logic [DATA_W-1:0] st_wdata,
   input  logic [TAG_W-1:0]  st_tag_q,
   input  logic              st_valid_q,
   input  logic [DATA_W-1:0] st_data_q,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   state_t              state_reg;
   logic                req_we_reg;
   logic [ADDR_W-1:0]   req_addr_reg;
   logic [DATA_W-1:0]   req_wdata_reg;
   logic [WORD_W-1:0]   k_reg;
   logic                refilled_reg;
   logic                hit;
   logic                last_word;
   logic                unused_addr_bits;

   assign hit              = st_valid_q && (st_tag_q == get_tag(req_addr_reg));
   assign last_word        = &k_reg;
   assign unused_addr_bits = ^req_addr_reg[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         req_we_reg    <= 1'b0;
         req_addr_reg  <= '0;
         req_wdata_reg <= '0;
         k_reg         <= '0;
         refilled_reg  <= 1'b0;
         hit_cnt       <= '0;
         miss_cnt      <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (cpu_req) begin
                  req_we_reg    <= cpu_we;
                  req_addr_reg  <= cpu_addr;
                  req_wdata_reg <= cpu_wdata;
                  state_reg     <= COMPARE;
               end
            end
            COMPARE: begin
               refilled_reg <= 1'b0;
               if (hit) begin
                  // The hit that completes a refilled load was already counted as a miss
                  if (!refilled_reg && hit_cnt != '1)
                     hit_cnt <= hit_cnt + CNT_W'(1);
                  state_reg <= req_we_reg ? WRITE_MEM : IDLE;
               end else begin
                  if (miss_cnt != '1)
                     miss_cnt <= miss_cnt + CNT_W'(1);
                  if (req_we_reg) begin
                     state_reg <= WRITE_MEM;
                  end else begin
                     k_reg     <= '0;
                     state_reg <= REFILL;
                  end
               end
            end
            REFILL: begin
               if (mem_ack) begin
                  k_reg <= k_reg + WORD_W'(1);
                  if (last_word) begin
                     refilled_reg <= 1'b1;
                     state_reg    <= COMPARE;
                  end
               end
            end
            WRITE_MEM: begin
               if (mem_ack)
                  state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_comb begin
      cpu_rdata  = '0;
      cpu_ready  = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      st_we_data = 1'b0;
      st_we_tag  = 1'b0;
      st_tag     = '0;
      st_wdata   = '0;
      st_index   = get_index(req_addr_reg);
      st_word    = get_word(req_addr_reg);
      case (state_reg)
         IDLE: begin
            // Look up with the live address so the tag is ready in COMPARE
            st_index = get_index(cpu_addr);
            st_word  = get_word(cpu_addr);
         end
         COMPARE: begin
            if (hit) begin
               if (req_we_reg) begin
                  st_we_data = 1'b1;
                  st_wdata   = req_wdata_reg;
               end else begin
                  cpu_ready = 1'b1;
                  cpu_rdata = st_data_q;
               end
            end
         end
         REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {get_tag(req_addr_reg), get_index(req_addr_reg), k_reg, 2'b00};
            st_word  = k_reg;
            st_tag   = get_tag(req_addr_reg);
            if (mem_ack) begin
               st_we_data = 1'b1;
               st_wdata   = mem_rdata;
               st_we_tag  = last_word;
            end
         end
         WRITE_MEM: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {get_tag(req_addr_reg), get_index(req_addr_reg),
                         get_word(req_addr_reg), 2'b00};
            mem_wdata = req_wdata_reg;
            cpu_ready = mem_ack;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural storage and memory, a cache-content model,
// and a per-cycle compare process checking memory traffic, tag writes and load data.
`timescale 1ns/1ps
module tb_cache_ctrl;
   import cache_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cpu_req = 1'b0;
   logic              cpu_we = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic [DATA_W-1:0] cpu_wdata = '0;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ready;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic [INDEX_W-1:0] st_index;
   logic [WORD_W-1:0] st_word;
   logic              st_we_data;
   logic              st_we_tag;
   logic [TAG_W-1:0]  st_tag;
   logic [DATA_W-1:0] st_wdata;
   logic [TAG_W-1:0]  st_tag_q;
   logic              st_valid_q;
   logic [DATA_W-1:0] st_data_q;
   logic [CNT_W-1:0]  hit_cnt;
   logic [CNT_W-1:0]  miss_cnt;

   always #5 clk = ~clk;

   cache_ctrl dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .st_index(st_index), .st_word(st_word), .st_we_data(st_we_data),
      .st_we_tag(st_we_tag), .st_tag(st_tag), .st_wdata(st_wdata),
      .st_tag_q(st_tag_q), .st_valid_q(st_valid_q), .st_data_q(st_data_q),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Storage array: async read, valid bits cleared by reset
   logic [TAG_W-1:0]  s_tag   [32];
   logic              s_valid [32];
   logic [DATA_W-1:0] s_data  [32][8];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) s_valid[i] <= 1'b0;
      end else begin
         if (st_we_data) s_data[st_index][st_word] <= st_wdata;
         if (st_we_tag) begin
            s_tag[st_index]   <= st_tag;
            s_valid[st_index] <= 1'b1;
         end
      end
   end
   assign st_tag_q   = s_tag[st_index];
   assign st_valid_q = s_valid[st_index];
   assign st_data_q  = s_data[st_index][st_word];

   // Word memory with optional random wait states
   logic [DATA_W-1:0] mem_model [16384];
   logic              ack_en = 1'b1;
   int                mem_wait = 0;
   assign mem_rdata = mem_model[mem_addr[15:2]];
   assign mem_ack   = mem_req && ack_en;
   initial forever begin
      @(posedge clk);
      #2;
      ack_en = (mem_wait == 0) || ($urandom_range(0, 2) == 0);
   end

   // Expectations shared between the stimulus and the compare process
   typedef struct packed {
      logic [15:0] addr;
      logic        we;
      logic [31:0] wdata;
   } mem_op_t;
   mem_op_t     exp_mem [$];
   logic [15:0] obs_addr [$];
   int          exp_tag_cnt = 0;
   logic [5:0]  exp_tag_val = '0;
   logic [4:0]  exp_tag_idx = '0;
   logic        exp_pending = 1'b0;
   logic        exp_load = 1'b0;
   logic [31:0] exp_rdata = '0;
   logic [31:0] last_rdata = '0;
   int          exp_hit = 0;
   int          exp_miss = 0;
   logic        mvalid [32];
   logic [5:0]  mtag [32];

   // Compare process; also owns the memory contents (init and write-through)
   initial begin
      logic        prev_wait;
      logic [15:0] prev_addr;
      logic        prev_we;
      mem_op_t     e;
      prev_wait = 1'b0;
      prev_addr = '0;
      prev_we   = 1'b0;
      for (int i = 0; i < 16384; i++) mem_model[i] = {16'hBEE0, 16'(i)};
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_wait = 1'b0;
            continue;
         end
         if (mem_req && prev_wait) begin
            check("mem_addr_stable", mem_addr, prev_addr);
            check("mem_we_stable", mem_we, prev_we);
         end
         if (mem_req && mem_ack) begin
            obs_addr.push_back(mem_addr);
            if (exp_mem.size() == 0) begin
               check("unexpected_mem_op", 1, 0);
            end else begin
               e = exp_mem.pop_front();
               check("mem_addr", mem_addr, e.addr);
               check("mem_we", mem_we, e.we);
               if (e.we) check("mem_wdata", mem_wdata, e.wdata);
            end
            if (mem_we) mem_model[mem_addr[15:2]] = mem_wdata;
         end
         prev_wait = mem_req && !mem_ack;
         prev_addr = mem_addr;
         prev_we   = mem_we;
         if (st_we_tag) begin
            if (exp_tag_cnt == 0) begin
               check("unexpected_tag_write", 1, 0);
            end else begin
               check("st_tag", st_tag, exp_tag_val);
               check("st_tag_index", st_index, exp_tag_idx);
               exp_tag_cnt--;
            end
         end
         if (cpu_ready) begin
            check("ready_expected", exp_pending, 1);
            if (exp_pending && exp_load) check("cpu_rdata", cpu_rdata, exp_rdata);
            last_rdata = cpu_rdata;
         end
      end
   end

   // Cache-content model: decides hit/miss and the memory traffic a request causes
   task automatic expect_req(input logic we, input logic [15:0] addr, input logic [31:0] wdata);
      logic [4:0] idx;
      logic [5:0] tag;
      logic       is_hit;
      idx    = addr[9:5];
      tag    = addr[15:10];
      is_hit = mvalid[idx] && (mtag[idx] == tag);
      if (is_hit) exp_hit++;
      else        exp_miss++;
      if (!we && !is_hit) begin
         for (int k = 0; k < 8; k++)
            exp_mem.push_back('{addr: {addr[15:5], 3'(k), 2'b00}, we: 1'b0, wdata: 32'h0});
         exp_tag_cnt = 1;
         exp_tag_val = tag;
         exp_tag_idx = idx;
         mvalid[idx] = 1'b1;
         mtag[idx]   = tag;
      end
      if (we) exp_mem.push_back('{addr: {addr[15:2], 2'b00}, we: 1'b1, wdata: wdata});
      exp_load  = !we;
      exp_rdata = mem_model[addr[15:2]];
   endtask

   // Called at posedge+1; exp_lat < 0 skips the latency check (wait-state runs)
   task automatic do_req(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                         input int exp_lat);
      int n;
      expect_req(we, addr, wdata);
      obs_addr.delete();
      exp_pending = 1'b1;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cpu_ready && n < 400);
      if (!cpu_ready) check("ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      cpu_req     = 1'b0;
      exp_pending = 1'b0;
      if (exp_lat >= 0) check("latency", n - 1, exp_lat);
      check("hit_cnt", hit_cnt, exp_hit);
      check("miss_cnt", miss_cnt, exp_miss);
      check("mem_ops_left", exp_mem.size(), 0);
      check("tag_writes_left", exp_tag_cnt, 0);
      $display("txn we=%0d addr=%h wdata=%h lat=%0d rdata=%h hits=%0d misses=%0d mem_ops=%0d",
               we, addr, wdata, n - 1, last_rdata, hit_cnt, miss_cnt, obs_addr.size());
   endtask

   task automatic reset_mid_refill(input logic [15:0] addr);
      int n;
      expect_req(1'b0, addr, 32'h0);
      obs_addr.delete();
      exp_pending = 1'b1;
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = addr;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (obs_addr.size() < 3 && n < 100);
      check("acks_before_reset", obs_addr.size(), 3);
      @(posedge clk);
      #1;
      rst         = 1'b1;
      cpu_req     = 1'b0;
      exp_pending = 1'b0;
      exp_mem.delete();
      exp_tag_cnt = 0;
      exp_hit     = 0;
      exp_miss    = 0;
      for (int i = 0; i < 32; i++) mvalid[i] = 1'b0;
      #1;
      check("rst_mem_req", mem_req, 0);
      check("rst_cpu_ready", cpu_ready, 0);
      check("rst_st_we_data", st_we_data, 0);
      check("rst_miss_cnt", miss_cnt, 0);
      repeat (2) @(posedge clk);
      check("rst_hold_cpu_ready", cpu_ready, 0);
      #1;
      rst = 1'b0;
      $display("txn reset during refill of %h after %0d acks", addr, obs_addr.size());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) begin
         mvalid[i] = 1'b0;
         mtag[i]   = '0;
         s_tag[i]  = '0;
      end
      #3;
      check("reset_cpu_ready", cpu_ready, 0);
      check("reset_mem_req", mem_req, 0);
      check("reset_mem_we", mem_we, 0);
      check("reset_mem_addr", mem_addr, 0);
      check("reset_cpu_rdata", cpu_rdata, 0);
      check("reset_st_we", {st_we_data, st_we_tag}, 0);
      check("reset_hit_cnt", hit_cnt, 0);
      check("reset_miss_cnt", miss_cnt, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Cold miss: tag 4, index 17, word 5
      do_req(1'b0, 16'h1234, 32'h0, 10);
      check("first_rdata_literal", last_rdata, 32'hBEE0048D);
      check("refill_first_addr", obs_addr[0], 16'h1220);
      check("refill_last_addr", obs_addr[7], 16'h123C);
      check("miss_cnt_literal", miss_cnt, 1);

      do_req(1'b0, 16'h1234, 32'h0, 1);
      check("hit_rdata_literal", last_rdata, 32'hBEE0048D);
      check("hit_cnt_literal", hit_cnt, 1);

      do_req(1'b1, 16'h1234, 32'hDEADBEEF, 2);
      check("storage_word_literal", s_data[17][5], 32'hDEADBEEF);
      check("mem_word_literal", mem_model[14'h048D], 32'hDEADBEEF);
      do_req(1'b0, 16'h1234, 32'h0, 1);
      check("store_hit_readback", last_rdata, 32'hDEADBEEF);
      do_req(1'b0, 16'h1238, 32'h0, 1);

      // Wait-state phase: store miss, following load miss, conflict misses
      mem_wait = 1;
      do_req(1'b1, 16'h2000, 32'h0BADF00D, -1);
      do_req(1'b0, 16'h2000, 32'h0, -1);
      check("no_alloc_rdata", last_rdata, 32'h0BADF00D);
      do_req(1'b0, 16'h5234, 32'h0, -1);
      do_req(1'b0, 16'h1234, 32'h0, -1);
      check("conflict_rdata_literal", last_rdata, 32'hDEADBEEF);
      check("hits_literal", hit_cnt, 4);
      check("misses_literal", miss_cnt, 5);

      // Abort a refill with reset, then refill again from word 0
      mem_wait = 0;
      reset_mid_refill(16'h5234);
      do_req(1'b0, 16'h1234, 32'h0, 10);
      check("post_reset_first_addr", obs_addr[0], 16'h1220);
      check("post_reset_rdata", last_rdata, 32'hDEADBEEF);
      check("post_reset_miss_literal", miss_cnt, 1);
      do_req(1'b0, 16'h1220, 32'h0, 1);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
